mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_pkg.sv | 13 +
 rtl/mem_copy_dma.sv | 128 ++++++++++++
 tb/tb_mem_copy_dma.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared definitions for the word-copy DMA: FSM state encoding and word size.
package mem_copy_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: alternates READ/WRITE cycles against a single-port data memory.
// Optional fill mode (constant pattern write, no reads) is enabled by defining DMA_FILL_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs parked at zero
// READ  | source word on the bus, captured into buffer at the edge
// WRITE | buffer written to destination; pointers advance, remaining count drops
// DONE  | one-cycle completion pulse
module mem_copy_dma
   import mem_copy_pkg::*;
#(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [CNT_W-1:0] count,
`ifdef DMA_FILL_EN
   input  logic             fill_mode,
   input  logic [31:0]      fill_value,
`endif
   output logic             busy,
   output logic             done,
   output logic [31:0]      address_to_mem,
   output logic [31:0]      data_to_mem,
   output logic             write_enable,
   input  logic [31:0]      data_from_mem
);

   localparam logic [31:0] STEP = 32'(WORD_BYTES);

   state_e           state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [31:0]      buf_q, buf_d;
   logic             fill_q;
   logic             fill_req;
   logic [31:0]      fill_word;

`ifdef DMA_FILL_EN
   logic fill_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) fill_q <= 1'b0;
      else        fill_q <= fill_d;
   end

   always_comb begin
      fill_d = fill_q;
      if (state_q == IDLE && start) fill_d = fill_mode;
   end

   assign fill_req  = fill_mode;
   assign fill_word = fill_value;
`else
   assign fill_q    = 1'b0;
   assign fill_req  = 1'b0;
   assign fill_word = 32'h0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      src_d          = src_q;
      dst_d          = dst_q;
      rem_d          = rem_q;
      buf_d          = buf_q;
      address_to_mem = '0;
      data_to_mem    = '0;
      write_enable   = 1'b0;
      done           = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               src_d = src_addr & ~32'h3;
               dst_d = dst_addr & ~32'h3;
               rem_d = count;
               // Fill mode preloads the buffer so WRITE needs no special data path.
               if (fill_req) buf_d = fill_word;
               if (count == '0)   state_d = DONE;
               else if (fill_req) state_d = WRITE;
               else               state_d = READ;
            end
         end
         READ: begin
            address_to_mem = src_q;
            buf_d          = data_from_mem;
            state_d        = WRITE;
         end
         WRITE: begin
            address_to_mem = dst_q;
            data_to_mem    = buf_q;
            write_enable   = 1'b1;
            src_d          = src_q + STEP;
            dst_d          = dst_q + STEP;
            rem_d          = rem_q - CNT_W'(1);
            if (rem_q > CNT_W'(1)) state_d = fill_q ? WRITE : READ;
            else                   state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: directed corner cases plus random copies
// against an array-based reference model; fill cases run only when DMA_FILL_EN is defined.
module tb_mem_copy_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] src_addr, dst_addr;
   logic [9:0]  count;
   logic        busy, done, write_enable;
   logic [31:0] address_to_mem, data_to_mem, data_from_mem;
`ifdef DMA_FILL_EN
   logic        fill_mode;
   logic [31:0] fill_value;
`endif

   logic [31:0] ram   [256];
   logic [31:0] model [256];
   logic        tb_wr;
   logic [7:0]  tb_idx;
   logic [31:0] tb_dat;

   logic [31:0] wq_addr[$], wq_data[$], rq_addr[$];
   logic [31:0] ew_addr[$], ew_data[$], er_addr[$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_copy_dma #(.CNT_W(10)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .count          (count),
`ifdef DMA_FILL_EN
      .fill_mode      (fill_mode),
      .fill_value     (fill_value),
`endif
      .busy           (busy),
      .done           (done),
      .address_to_mem (address_to_mem),
      .data_to_mem    (data_to_mem),
      .write_enable   (write_enable),
      .data_from_mem  (data_from_mem)
   );

   // Data memory model: 256 words aliased on address bits [9:2], combinational read.
   assign data_from_mem = ram[address_to_mem[9:2]];

   always @(posedge clk) begin
      if (tb_wr)             ram[tb_idx] <= tb_dat;
      else if (write_enable) ram[address_to_mem[9:2]] <= data_to_mem;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input int i, input logic [31:0] v);
      tb_idx = i[7:0];
      tb_dat = v;
      tb_wr  = 1'b1;
      model[i] = v;
      @(negedge clk);
      tb_wr = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, {31'b0, busy}, 32'h0);
      check({tag, "_done"}, {31'b0, done}, 32'h0);
      check({tag, "_we"},   {31'b0, write_enable}, 32'h0);
      check({tag, "_addr"}, address_to_mem, 32'h0);
      check({tag, "_data"}, data_to_mem, 32'h0);
   endtask

   // Runs one transfer starting at a negedge. abort_at>0 pulls reset after that many writes.
   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                           input bit fill, input logic [31:0] fval, input int abort_at);
      logic [31:0] s, d, ra, wa, v;
      int cyc, lat, nw, nbad;
      bit got_done, aborted;
      s = src & ~32'h3;
      d = dst & ~32'h3;
      nw = (abort_at > 0) ? abort_at : cnt;
      ew_addr.delete(); ew_data.delete(); er_addr.delete();
      wq_addr.delete(); wq_data.delete(); rq_addr.delete();
      // Reference: ascending word-at-a-time copy, so overlap behaves like a forward memmove-less copy.
      for (int i = 0; i < cnt; i++) begin
         ra = s + 32'(4 * i);
         wa = d + 32'(4 * i);
         v  = fill ? fval : model[ra[9:2]];
         if (!fill) er_addr.push_back(ra);
         if (i < nw) begin
            model[wa[9:2]] = v;
            ew_addr.push_back(wa);
            ew_data.push_back(v);
         end
      end

      src_addr = src;
      dst_addr = dst;
      count    = cnt[9:0];
`ifdef DMA_FILL_EN
      fill_mode  = fill;
      fill_value = fval;
`endif
      start = 1'b1;
      cyc = 0; lat = -1; got_done = 0; aborted = 0;
      while (!got_done && !aborted && cyc < 4 * cnt + 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (cyc == 3 && busy) begin
            start    = 1'b1;
            src_addr = 32'h200;
            dst_addr = 32'h300;
            count    = 10'd7;
         end else if (cyc == 4) start = 1'b0;
         if (write_enable) begin
            wq_addr.push_back(address_to_mem);
            wq_data.push_back(data_to_mem);
         end else if (busy && !done) rq_addr.push_back(address_to_mem);
         if (done) begin
            got_done = 1;
            lat = cyc;
         end
         if (abort_at > 0 && wq_addr.size() == abort_at && !write_enable && !done) begin
            reset = 1'b0;
            #1;
            check_idle_outputs("abort");
            repeat (3) begin
               @(negedge clk);
               check("abort_no_done", {31'b0, done}, 32'h0);
            end
            reset = 1'b1;
            aborted = 1;
         end
      end
      start = 1'b0;

      if (abort_at > 0) begin
         check("abort_reached", {31'b0, aborted}, 32'h1);
      end else begin
         check("done_seen", {31'b0, got_done}, 32'h1);
         check("latency", lat, fill ? cnt + 1 : 2 * cnt + 1);
         @(negedge clk);
         check("done_one_cycle", {31'b0, done}, 32'h0);
         check("idle_after", {31'b0, busy}, 32'h0);
         if (!fill) begin
            check("n_reads", rq_addr.size(), er_addr.size());
            for (int i = 0; i < er_addr.size() && i < rq_addr.size(); i++)
               check("read_addr", rq_addr[i], er_addr[i]);
         end
      end
      check("n_writes", wq_addr.size(), ew_addr.size());
      for (int i = 0; i < ew_addr.size() && i < wq_addr.size(); i++) begin
         check("write_addr", wq_addr[i], ew_addr[i]);
         check("write_data", wq_data[i], ew_data[i]);
      end
      @(negedge clk);
      nbad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== model[i]) nbad++;
      check("ram_mismatches", nbad, 0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0;
      src_addr = '0; dst_addr = '0; count = '0;
      tb_wr = 1'b0; tb_idx = '0; tb_dat = '0;
`ifdef DMA_FILL_EN
      fill_mode = 1'b0; fill_value = '0;
`endif
      #1;
      check_idle_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 256; i++) poke(i, $urandom);

      poke(4, 32'h11); poke(5, 32'h22); poke(6, 32'h33); poke(7, 32'h44);
      run_xfer(32'h10, 32'h40, 4, 0, 32'h0, 0);
      check("ram16", ram[16], 32'h11);
      check("ram17", ram[17], 32'h22);
      check("ram18", ram[18], 32'h33);
      check("ram19", ram[19], 32'h44);

      run_xfer(32'h80, 32'h90, 0, 0, 32'h0, 0);

      run_xfer(32'h13, 32'h22, 1, 0, 32'h0, 0);
      check("unaligned_rd", rq_addr[0], 32'h10);
      check("unaligned_wr", wq_addr[0], 32'h20);

      run_xfer(32'h100, 32'hFFFF_FFFC, 2, 0, 32'h0, 0);
      check("wrap_wr0", wq_addr[0], 32'hFFFF_FFFC);
      check("wrap_wr1", wq_addr[1], 32'h0000_0000);

      run_xfer(32'h140, 32'h1C0, 4, 0, 32'h0, 2);
      run_xfer(32'h20, 32'h24, 5, 0, 32'h0, 0);

      for (int t = 0; t < 25; t++)
         run_xfer($urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 12), 0, 32'h0, 0);

`ifdef DMA_FILL_EN
      run_xfer(32'h3F0, 32'h0, 3, 1, 32'hDEAD_BEEF, 0);
      check("fill0", ram[0], 32'hDEAD_BEEF);
      check("fill1", ram[1], 32'hDEAD_BEEF);
      check("fill2", ram[2], 32'hDEAD_BEEF);
      for (int t = 0; t < 6; t++)
         run_xfer($urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 9), 1, $urandom, 0);
      run_xfer(32'h44, 32'h88, 3, 0, 32'h0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
